// File: rtl/rob_wb_arbiter_if.sv
// Result-producer / CDB bundle for the ROB write-back arbiter.
// master = producers and CDB consumers, slave = the arbiter itself.
interface rob_wb_arbiter_if #(
   parameter int WORD_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int ROB_IDX_W = 4
);
   logic                 rdy_in;
   logic                 clear_branch_in;
   logic                 ex_en_in;
   logic [WORD_W-1:0]    ex_res_in;
   logic                 ex_jump_en_in;
   logic [ADDR_W-1:0]    ex_jump_a_in;
   logic [ROB_IDX_W-1:0] ex_rob_pos_in;
   logic                 ex_full_out;
   logic                 lsb_r_en_in;
   logic [WORD_W-1:0]    lsb_res_in;
   logic [ROB_IDX_W-1:0] lsb_rob_pos_r_in;
   logic                 lsb_r_full_out;
   logic                 lsb_w_en_in;
   logic [ROB_IDX_W-1:0] lsb_rob_pos_w_in;
   logic                 lsb_w_full_out;
   logic                 cdb_en_out;
   logic [1:0]           cdb_src_out;
   logic [ROB_IDX_W-1:0] cdb_rob_pos_out;
   logic [WORD_W-1:0]    cdb_res_out;
   logic                 cdb_jump_en_out;
   logic [ADDR_W-1:0]    cdb_jump_a_out;
   logic                 busy_out;
   logic                 overflow_err_out;

   modport master (
      output rdy_in, clear_branch_in,
      output ex_en_in, ex_res_in, ex_jump_en_in, ex_jump_a_in, ex_rob_pos_in,
      output lsb_r_en_in, lsb_res_in, lsb_rob_pos_r_in,
      output lsb_w_en_in, lsb_rob_pos_w_in,
      input  ex_full_out, lsb_r_full_out, lsb_w_full_out,
      input  cdb_en_out, cdb_src_out, cdb_rob_pos_out, cdb_res_out,
      input  cdb_jump_en_out, cdb_jump_a_out, busy_out, overflow_err_out
   );

   modport slave (
      input  rdy_in, clear_branch_in,
      input  ex_en_in, ex_res_in, ex_jump_en_in, ex_jump_a_in, ex_rob_pos_in,
      input  lsb_r_en_in, lsb_res_in, lsb_rob_pos_r_in,
      input  lsb_w_en_in, lsb_rob_pos_w_in,
      output ex_full_out, lsb_r_full_out, lsb_w_full_out,
      output cdb_en_out, cdb_src_out, cdb_rob_pos_out, cdb_res_out,
      output cdb_jump_en_out, cdb_jump_a_out, busy_out, overflow_err_out
   );
endinterface

// File: rtl/rob_wb_arbiter.sv
// ROB write-back arbiter: three skid FIFOs (EX, LOAD, STORE) with
// round-robin grant onto a registered single-port CDB.
module rob_wb_arbiter #(
   parameter int WORD_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int ROB_IDX_W = 4,
   parameter int DEPTH     = 2
) (
   input logic              clk_in,
   input logic              rst_in,
   rob_wb_arbiter_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] SRC_EX = 2'd0;
   localparam logic [1:0] SRC_LD = 2'd1;
   localparam logic [1:0] SRC_ST = 2'd2;

   typedef struct packed {
      logic [WORD_W-1:0]    res;
      logic                 jump_en;
      logic [ADDR_W-1:0]    jump_a;
      logic [ROB_IDX_W-1:0] pos;
   } entry_t;

   entry_t         mem [3][DEPTH];
   logic [PW-1:0]  rd_ptr [3];
   logic [PW-1:0]  wr_ptr [3];
   logic [CW-1:0]  cnt [3];
   logic [1:0]     rr;
   entry_t         in_ent [3];
   logic [2:0]     en, has, full, cand, grant, push, pop;
   logic [1:0]     gsel;
   logic           gany;
   entry_t         sel_ent;
   logic           norm;

   logic           cdb_vld_p1;
   logic [1:0]     cdb_src_p1;
   entry_t         cdb_ent_p1;
   logic           ovf;

   function automatic logic [1:0] rr_next(input logic [1:0] s);
      return (s == SRC_ST) ? SRC_EX : s + 2'd1;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign norm = bus.rdy_in & ~bus.clear_branch_in;
   assign en   = {bus.lsb_w_en_in, bus.lsb_r_en_in, bus.ex_en_in};

   always_comb begin
      in_ent[SRC_EX] = '{res: bus.ex_res_in, jump_en: bus.ex_jump_en_in,
                         jump_a: bus.ex_jump_a_in, pos: bus.ex_rob_pos_in};
      in_ent[SRC_LD] = '{res: bus.lsb_res_in, jump_en: 1'b0,
                         jump_a: '0, pos: bus.lsb_rob_pos_r_in};
      in_ent[SRC_ST] = '{res: '0, jump_en: 1'b0,
                         jump_a: '0, pos: bus.lsb_rob_pos_w_in};
      for (int s = 0; s < 3; s++) begin
         has[s]  = (cnt[s] != '0);
         full[s] = (cnt[s] == CW'(DEPTH));
         cand[s] = has[s] | en[s];
      end
   end

   // Scan the sources starting just after the last winner.
   always_comb begin
      logic [1:0] c;
      c     = rr;
      gsel  = rr;
      gany  = 1'b0;
      grant = '0;
      for (int i = 0; i < 3; i++) begin
         c = rr_next(c);
         if (!gany && cand[c]) begin
            gany = 1'b1;
            gsel = c;
         end
      end
      if (gany) grant[gsel] = 1'b1;
      for (int s = 0; s < 3; s++) begin
         pop[s]  = grant[s] & has[s];
         push[s] = en[s] & ~(grant[s] & ~has[s]) & ~full[s];
      end
      sel_ent = has[gsel] ? mem[gsel][rd_ptr[gsel]] : in_ent[gsel];
   end

   // FIFO storage carries data only, so it is left out of reset.
   always_ff @(posedge clk_in) begin
      for (int s = 0; s < 3; s++)
         if (norm && push[s]) mem[s][wr_ptr[s]] <= in_ent[s];
   end

   // Stage boundary: grant result registered onto the CDB.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int s = 0; s < 3; s++) begin
            cnt[s]    <= '0;
            rd_ptr[s] <= '0;
            wr_ptr[s] <= '0;
         end
         rr         <= SRC_ST;
         cdb_vld_p1 <= 1'b0;
         cdb_src_p1 <= '0;
         cdb_ent_p1 <= '0;
         ovf        <= 1'b0;
      end else if (bus.clear_branch_in && bus.rdy_in) begin
         for (int s = 0; s < 3; s++) begin
            cnt[s]    <= '0;
            rd_ptr[s] <= '0;
            wr_ptr[s] <= '0;
         end
         rr         <= SRC_ST;
         cdb_vld_p1 <= 1'b0;
      end else if (!bus.rdy_in) begin
         cdb_vld_p1 <= 1'b0;
      end else begin
         for (int s = 0; s < 3; s++) begin
            if (push[s]) wr_ptr[s] <= ptr_inc(wr_ptr[s]);
            if (pop[s])  rd_ptr[s] <= ptr_inc(rd_ptr[s]);
            cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
         end
         if (|(en & full)) ovf <= 1'b1;
         cdb_vld_p1 <= gany;
         if (gany) begin
            rr         <= gsel;
            cdb_src_p1 <= gsel;
            cdb_ent_p1 <= sel_ent;
         end
      end
   end

   assign bus.ex_full_out      = full[SRC_EX];
   assign bus.lsb_r_full_out   = full[SRC_LD];
   assign bus.lsb_w_full_out   = full[SRC_ST];
   assign bus.cdb_en_out       = cdb_vld_p1;
   assign bus.cdb_src_out      = cdb_src_p1;
   assign bus.cdb_rob_pos_out  = cdb_ent_p1.pos;
   assign bus.cdb_res_out      = cdb_ent_p1.res;
   assign bus.cdb_jump_en_out  = cdb_ent_p1.jump_en;
   assign bus.cdb_jump_a_out   = cdb_ent_p1.jump_a;
   assign bus.busy_out         = |has;
   assign bus.overflow_err_out = ovf;
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: latency, round-robin order, overflow,
// branch flush and rdy freeze, with hand-computed expectations.
module tb_rob_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [31:0] load_q [$];

   rob_wb_arbiter_if #(.WORD_W(32), .ADDR_W(32), .ROB_IDX_W(4)) bus ();

   rob_wb_arbiter #(.WORD_W(32), .ADDR_W(32), .ROB_IDX_W(4), .DEPTH(2)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.rdy_in = 1'b1;           bus.clear_branch_in = 1'b0;
      bus.ex_en_in = 1'b0;         bus.ex_res_in = '0;
      bus.ex_jump_en_in = 1'b0;    bus.ex_jump_a_in = '0;
      bus.ex_rob_pos_in = '0;      bus.lsb_r_en_in = 1'b0;
      bus.lsb_res_in = '0;         bus.lsb_rob_pos_r_in = '0;
      bus.lsb_w_en_in = 1'b0;      bus.lsb_rob_pos_w_in = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_ex(input logic [31:0] res, input logic [3:0] pos);
      bus.ex_en_in = 1'b1; bus.ex_res_in = res; bus.ex_rob_pos_in = pos;
      bus.ex_jump_en_in = 1'b0; bus.ex_jump_a_in = '0;
   endtask

   // Leaves EX FIFO holding 0x4A (pos 4) then 0x4B (pos 5); CDB shows STORE pos 2.
   task automatic setup_ex2();
      do_reset();
      send_ex(32'h400, 4'd0);
      bus.lsb_r_en_in = 1'b1; bus.lsb_res_in = 32'h41; bus.lsb_rob_pos_r_in = 4'd1;
      bus.lsb_w_en_in = 1'b1; bus.lsb_rob_pos_w_in = 4'd2;
      tick(); idle();
      check_val("setup_e0_src", 64'(bus.cdb_src_out), 64'd0);
      check_val("setup_e0_res", 64'(bus.cdb_res_out), 64'h400);
      send_ex(32'h4A, 4'd4);
      tick(); idle();
      check_val("setup_e1_src", 64'(bus.cdb_src_out), 64'd1);
      send_ex(32'h4B, 4'd5);
      tick(); idle();
      check_val("setup_e2_src", 64'(bus.cdb_src_out), 64'd2);
      check_val("setup_ex_full", 64'(bus.ex_full_out), 64'd1);
   endtask

   initial begin
      int nl, ne, found;

      // Reset state and single EX pulse
      do_reset();
      check_val("rst_cdb_en", 64'(bus.cdb_en_out), 64'd0);
      check_val("rst_busy", 64'(bus.busy_out), 64'd0);
      check_val("rst_ex_full", 64'(bus.ex_full_out), 64'd0);
      check_val("rst_ovf", 64'(bus.overflow_err_out), 64'd0);
      check_val("rst_res", 64'(bus.cdb_res_out), 64'd0);
      bus.ex_en_in = 1'b1; bus.ex_res_in = 32'h1234; bus.ex_jump_en_in = 1'b1;
      bus.ex_jump_a_in = 32'h80; bus.ex_rob_pos_in = 4'd3;
      tick(); idle();
      check_val("t1_en", 64'(bus.cdb_en_out), 64'd1);
      check_val("t1_src", 64'(bus.cdb_src_out), 64'd0);
      check_val("t1_pos", 64'(bus.cdb_rob_pos_out), 64'd3);
      check_val("t1_res", 64'(bus.cdb_res_out), 64'h1234);
      check_val("t1_jen", 64'(bus.cdb_jump_en_out), 64'd1);
      check_val("t1_ja", 64'(bus.cdb_jump_a_out), 64'h80);
      tick();
      check_val("t1_en_off", 64'(bus.cdb_en_out), 64'd0);
      check_val("t1_busy", 64'(bus.busy_out), 64'd0);

      // Three sources in one cycle
      do_reset();
      send_ex(32'h11, 4'd1);
      bus.lsb_r_en_in = 1'b1; bus.lsb_res_in = 32'hAA; bus.lsb_rob_pos_r_in = 4'd2;
      bus.lsb_w_en_in = 1'b1; bus.lsb_rob_pos_w_in = 4'd3;
      tick(); idle();
      check_val("t2_c0_src", 64'(bus.cdb_src_out), 64'd0);
      check_val("t2_c0_pos", 64'(bus.cdb_rob_pos_out), 64'd1);
      check_val("t2_c0_busy", 64'(bus.busy_out), 64'd1);
      tick();
      check_val("t2_c1_src", 64'(bus.cdb_src_out), 64'd1);
      check_val("t2_c1_pos", 64'(bus.cdb_rob_pos_out), 64'd2);
      check_val("t2_c1_res", 64'(bus.cdb_res_out), 64'hAA);
      tick();
      check_val("t2_c2_en", 64'(bus.cdb_en_out), 64'd1);
      check_val("t2_c2_src", 64'(bus.cdb_src_out), 64'd2);
      check_val("t2_c2_pos", 64'(bus.cdb_rob_pos_out), 64'd3);
      check_val("t2_c2_res", 64'(bus.cdb_res_out), 64'd0);
      check_val("t2_c2_busy", 64'(bus.busy_out), 64'd0);
      tick();
      check_val("t2_c3_en", 64'(bus.cdb_en_out), 64'd0);

      // EX stream with one LOAD: LOAD lands on the 2nd CDB cycle
      do_reset();
      for (int k = 0; k < 7; k++) begin
         idle();
         if (k < 6) send_ex(32'h300 + 32'(k), 4'(k));
         if (k == 0) begin
            bus.lsb_r_en_in = 1'b1; bus.lsb_res_in = 32'h55; bus.lsb_rob_pos_r_in = 4'd9;
         end
         tick();
         check_val($sformatf("t3_en_%0d", k), 64'(bus.cdb_en_out), 64'd1);
         check_val($sformatf("t3_src_%0d", k), 64'(bus.cdb_src_out), (k == 1) ? 64'd1 : 64'd0);
         check_val($sformatf("t3_res_%0d", k), 64'(bus.cdb_res_out),
                   (k == 0) ? 64'h300 : (k == 1) ? 64'h55 : 64'(32'h300 + 32'(k - 1)));
         check_val($sformatf("t3_full_%0d", k), 64'(bus.ex_full_out), 64'd0);
      end
      idle();
      tick();
      check_val("t3_ovf", 64'(bus.overflow_err_out), 64'd0);
      check_val("t3_busy", 64'(bus.busy_out), 64'd0);

      // LOAD overflow under saturating traffic
      do_reset();
      load_q.delete();
      nl = 0; ne = 0; found = 0;
      for (int k = 0; k < 30; k++) begin
         idle();
         if (bus.lsb_r_full_out) begin
            found = 1;
            break;
         end
         if (!bus.ex_full_out) begin send_ex(32'h100 + 32'(ne), 4'd0); ne++; end
         if (!bus.lsb_w_full_out) begin bus.lsb_w_en_in = 1'b1; bus.lsb_rob_pos_w_in = 4'd1; end
         bus.lsb_r_en_in = 1'b1; bus.lsb_res_in = 32'h200 + 32'(nl); nl++;
         tick();
         if (bus.cdb_en_out && bus.cdb_src_out == 2'd1) load_q.push_back(bus.cdb_res_out);
      end
      check_val("t4_full_seen", 64'(found), 64'd1);
      check_val("t4_ovf_before", 64'(bus.overflow_err_out), 64'd0);
      bus.lsb_r_en_in = 1'b1; bus.lsb_res_in = 32'hDEAD; bus.lsb_rob_pos_r_in = 4'd7;
      tick();
      if (bus.cdb_en_out && bus.cdb_src_out == 2'd1) load_q.push_back(bus.cdb_res_out);
      idle();
      check_val("t4_ovf_after", 64'(bus.overflow_err_out), 64'd1);
      for (int k = 0; k < 12; k++) begin
         tick();
         if (bus.cdb_en_out && bus.cdb_src_out == 2'd1) load_q.push_back(bus.cdb_res_out);
      end
      check_val("t4_load_count", 64'(load_q.size()), 64'(nl));
      foreach (load_q[i])
         check_val($sformatf("t4_load_%0d", i), 64'(load_q[i]), 64'(32'h200 + 32'(i)));
      check_val("t4_busy", 64'(bus.busy_out), 64'd0);
      check_val("t4_ovf_sticky", 64'(bus.overflow_err_out), 64'd1);

      // Branch clear with a simultaneous LOAD
      setup_ex2();
      bus.clear_branch_in = 1'b1;
      bus.lsb_r_en_in = 1'b1; bus.lsb_res_in = 32'h77; bus.lsb_rob_pos_r_in = 4'd7;
      tick(); idle();
      check_val("t5_en", 64'(bus.cdb_en_out), 64'd0);
      check_val("t5_busy", 64'(bus.busy_out), 64'd0);
      check_val("t5_ex_full", 64'(bus.ex_full_out), 64'd0);
      send_ex(32'h4C, 4'd6);
      bus.lsb_w_en_in = 1'b1; bus.lsb_rob_pos_w_in = 4'd8;
      tick(); idle();
      check_val("t5_first_src", 64'(bus.cdb_src_out), 64'd0);
      check_val("t5_first_res", 64'(bus.cdb_res_out), 64'h4C);
      tick();
      check_val("t5_second_src", 64'(bus.cdb_src_out), 64'd2);
      check_val("t5_second_pos", 64'(bus.cdb_rob_pos_out), 64'd8);
      tick();
      check_val("t5_drained_en", 64'(bus.cdb_en_out), 64'd0);
      check_val("t5_drained_busy", 64'(bus.busy_out), 64'd0);

      // rdy freeze with entries pending
      setup_ex2();
      bus.rdy_in = 1'b0;
      send_ex(32'hEE, 4'd14);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_val($sformatf("t6_en_%0d", k), 64'(bus.cdb_en_out), 64'd0);
         check_val($sformatf("t6_pos_%0d", k), 64'(bus.cdb_rob_pos_out), 64'd2);
         check_val($sformatf("t6_busy_%0d", k), 64'(bus.busy_out), 64'd1);
         check_val($sformatf("t6_full_%0d", k), 64'(bus.ex_full_out), 64'd1);
      end
      idle();
      tick();
      check_val("t6_r0_src", 64'(bus.cdb_src_out), 64'd0);
      check_val("t6_r0_res", 64'(bus.cdb_res_out), 64'h4A);
      tick();
      check_val("t6_r1_res", 64'(bus.cdb_res_out), 64'h4B);
      check_val("t6_r1_pos", 64'(bus.cdb_rob_pos_out), 64'd5);
      tick();
      check_val("t6_end_en", 64'(bus.cdb_en_out), 64'd0);
      check_val("t6_end_busy", 64'(bus.busy_out), 64'd0);
      check_val("t6_ovf", 64'(bus.overflow_err_out), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rob_wb_arbiter.md
Name: rob_wb_arbiter

Overview:
Write-back arbiter between the result producers (EX unit, LSB load path, LSB store-ack path) and the reorder buffer's single result write port (the CDB).
- Each producer feeds a small skid FIFO.
- A round-robin scheduler grants one result per cycle onto a registered CDB bus that drives the ROB and the RS/LSB wake-up logic.
- Branch-clear flushes all pending results.

Parameters:
WORD_W, 32, result / data word width
ADDR_W, 32, jump target address width
ROB_IDX_W, 4, ROB position width
DEPTH, 2, entries per source FIFO (power of two, >=1)

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global ready; low = freeze
clear_branch_in  input  1  mispredict flush
ex_en_in  input  1  EX result valid (one-cycle pulse)
ex_res_in  input  WORD_W  EX result
ex_jump_en_in  input  1  EX branch taken/redirect flag
ex_jump_a_in  input  ADDR_W  EX jump target
ex_rob_pos_in  input  ROB_IDX_W  EX destination ROB slot
ex_full_out  output  1  EX FIFO full; producer must hold off
lsb_r_en_in  input  1  load result valid
lsb_res_in  input  WORD_W  load data
lsb_rob_pos_r_in  input  ROB_IDX_W  load ROB slot
lsb_r_full_out  output  1  load FIFO full
lsb_w_en_in  input  1  store-done valid
lsb_rob_pos_w_in  input  ROB_IDX_W  store ROB slot
lsb_w_full_out  output  1  store FIFO full
cdb_en_out  output  1  CDB entry valid this cycle
cdb_src_out  output  2  0=EX, 1=LOAD, 2=STORE
cdb_rob_pos_out  output  ROB_IDX_W  target ROB slot
cdb_res_out  output  WORD_W  result (0 for STORE)
cdb_jump_en_out  output  1  jump flag (0 unless EX)
cdb_jump_a_out  output  ADDR_W  jump target (0 unless EX)
busy_out  output  1  any FIFO non-empty
overflow_err_out  output  1  sticky: an en arrived while its FIFO was full

Behaviour:
- Reset (async): all FIFOs empty, rr pointer = STORE (so EX has first priority), all outputs 0.
- Each clock edge is evaluated with the following priority.
  1. clear_branch_in && rdy_in: empty all FIFOs, reset rr to STORE, cdb_en_out <= 0, drop all incoming en. overflow_err_out is kept.
  2. !rdy_in: FIFOs and rr are frozen, incoming en is ignored, cdb_en_out <= 0, other CDB outputs hold.
  3. Otherwise (normal cycle), the steps below apply.
- Candidate per source:
  - FIFO non-empty: the FIFO head.
  - FIFO empty and en high: the incoming data (bypass).
- Grant:
  - The first candidate in round-robin order after rr (EX -> LOAD -> STORE -> EX).
  - rr <= granted source.
  - CDB registers load the granted entry; cdb_en_out <= 1.
  - No candidate: cdb_en_out <= 0, rr unchanged.
- Latency: with an empty FIFO and a grant, the result appears on the CDB one cycle after en (registered at the same edge).
- FIFO update per source:
  - Pop the head if granted and the FIFO was non-empty.
  - Push the incoming en if it was not consumed by bypass and full_out is 0.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Full/overflow:
  - full_out = (count == DEPTH), combinational from registered count. It does not account for a same-cycle pop.
  - en while full_out=1 is dropped and overflow_err_out <= 1 (cleared only by reset).
- Wrap-around: read/write pointers wrap modulo DEPTH. count has a width of clog2(DEPTH)+1.
- Ordering: results from the same source leave in arrival order. Between sources, only round-robin fairness is guaranteed. Worst-case wait for a head entry is 2 cycles while the other sources stay busy.
- busy_out = OR of the FIFO non-empty flags (registered state, combinational OR).

Test Plan:
- Single EX pulse (res=0x1234, pos=3, jump_en=1, a=0x80) into idle arbiter -> next cycle cdb_en_out=1, src=0, pos=3, res=0x1234, jump_en=1, jump_a=0x80; following cycle cdb_en_out=0, busy_out=0.
- EX (pos 1), LOAD (pos 2, res 0xAA), STORE (pos 3) all in one cycle after reset -> CDB emits pos 1, 2, 3 on three consecutive cycles, srcs 0, 1, 2; busy_out falls after the third.
- EX pulses every cycle for 6 cycles while LOAD pulses once at cycle 0 -> LOAD granted no later than the 2nd CDB cycle; all 6 EX results appear in order; DEPTH=2 never exceeded, overflow_err_out=0.
- Fill LOAD FIFO (blocked by continuous EX+STORE traffic) until lsb_r_full_out=1, then pulse lsb_r_en_in -> overflow_err_out=1, dropped entry never appears on the CDB.
- Two entries pending in EX FIFO, assert clear_branch_in with a simultaneous LOAD en -> next cycle cdb_en_out=0, all FIFOs empty, busy_out=0, LOAD entry lost; next EX pulse is granted first.
- rdy_in low for 3 cycles with entries pending -> cdb_en_out=0 throughout, FIFO contents intact; after rdy_in rises, emission resumes in the same order.
